gecco_vb_sr_loader: RTL and testbench

- Serialises voltage-board (GECCO VB) DAC configuration words onto the board's three-wire shift-register interface: clock, data, load.
- Accepts parallel words over a valid/ready stream from the register file / UART command path, shifts them out MSB-first at a divided rate, then pulses load once per frame.
- Sits directly upstream of the vb_clk / vb_data / vb_load pads on the devboard top.

---
 rtl/gecco_vb_sr_loader.sv | 155 +++++++++++++++
 tb/tb_gecco_vb_sr_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gecco_vb_sr_loader.sv
// Serialises parallel DAC configuration words onto the GECCO voltage-board
// three-wire shift-register interface (vb_clk / vb_data / vb_load).
module gecco_vb_sr_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned LOAD_LEN   = 4
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  vb_clk,
  output logic                  vb_data,
  output logic                  vb_load,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            words_shifted
);

  localparam int unsigned BitW = $clog2(DATA_WIDTH);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);
  localparam logic [7:0] DivLast  = 8'(CLK_DIV - 1);
  localparam logic [7:0] LoadLast = 8'(LOAD_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StWaitWord,
    StLoadGap,
    StLoad,
    StDone
  } state_e;

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic [BitW-1:0]       bit_q;
  // Holds only the bits not yet presented; the MSB goes straight to vb_data.
  logic [DATA_WIDTH-2:0] sr_q;
  logic                  last_q;
  logic                  in_ready_q;
  logic                  vb_clk_q;
  logic                  vb_data_q;
  logic                  vb_load_q;
  logic                  busy_q;
  logic                  done_q;
  logic [7:0]            words_q;
  logic                  accept;

  assign accept = in_valid & in_ready_q;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      sr_q       <= '0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      vb_clk_q   <= 1'b0;
      vb_data_q  <= 1'b0;
      vb_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      words_q    <= '0;
    end else begin
      case (state_q)
        StIdle, StWaitWord: begin
          if (state_q == StIdle) in_ready_q <= 1'b1;
          if (accept) begin
            sr_q       <= in_data[DATA_WIDTH-2:0];
            vb_data_q  <= in_data[DATA_WIDTH-1];
            last_q     <= in_last;
            bit_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StShiftLo;
            if (state_q == StIdle) words_q <= '0;
          end
        end
        StShiftLo: begin
          if (cnt_q == DivLast) begin
            cnt_q    <= '0;
            vb_clk_q <= 1'b1;
            state_q  <= StShiftHi;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StShiftHi: begin
          if (cnt_q == DivLast) begin
            cnt_q    <= '0;
            vb_clk_q <= 1'b0;
            if (bit_q < LastBit) begin
              vb_data_q <= sr_q[DATA_WIDTH-2];
              sr_q      <= sr_q << 1;
              bit_q     <= bit_q + 1'b1;
              state_q   <= StShiftLo;
            end else begin
              if (words_q != 8'hFF) words_q <= words_q + 8'd1;
              if (last_q) begin
                state_q <= StLoadGap;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= StWaitWord;
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StLoadGap: begin
          if (cnt_q == DivLast) begin
            cnt_q     <= '0;
            vb_load_q <= 1'b1;
            state_q   <= StLoad;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StLoad: begin
          if (cnt_q == LoadLast) begin
            cnt_q     <= '0;
            vb_load_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone: begin
          done_q     <= 1'b0;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign vb_clk        = vb_clk_q;
  assign vb_data       = vb_data_q;
  assign vb_load       = vb_load_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_shifted = words_q;

endmodule

// File: tb/tb_gecco_vb_sr_loader.sv
// Directed bench for gecco_vb_sr_loader: default build plus a 2-bit, CLK_DIV=1 build.
module tb_gecco_vb_sr_loader;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid, in_last;
  logic        in_ready, vb_clk, vb_data, vb_load, busy, done;
  logic [7:0]  words_shifted;

  logic [1:0]  b_in_data;
  logic        b_in_valid, b_in_last;
  logic        b_in_ready, b_vb_clk, b_vb_data, b_vb_load, b_busy, b_done;
  logic [7:0]  b_words_shifted;

  int passed = 0;
  int total  = 0;

  always #5 sysclk = ~sysclk;

  gecco_vb_sr_loader #(.DATA_WIDTH(16), .CLK_DIV(4), .LOAD_LEN(4)) dut_a (
    .sysclk(sysclk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .vb_clk(vb_clk), .vb_data(vb_data),
    .vb_load(vb_load), .busy(busy), .done(done), .words_shifted(words_shifted)
  );

  gecco_vb_sr_loader #(.DATA_WIDTH(2), .CLK_DIV(1), .LOAD_LEN(3)) dut_b (
    .sysclk(sysclk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_last(b_in_last), .in_ready(b_in_ready), .vb_clk(b_vb_clk), .vb_data(b_vb_data),
    .vb_load(b_vb_load), .busy(b_busy), .done(b_done), .words_shifted(b_words_shifted)
  );

  // Activity monitor on dut_a; sees each cycle's outputs at the closing edge.
  logic        mon_clr = 1'b1;
  logic        prev_clk = 1'b0, prev_load = 1'b0, prev_data = 1'b0;
  logic [63:0] bits = '0;
  int rises = 0, load_cyc = 0, load_pulses = 0, done_cnt = 0, busy_cyc = 0;
  int cyc = 0, last_fall = 0, load_rise = 0, data_err = 0;

  always @(posedge sysclk) begin
    cyc       <= cyc + 1;
    prev_clk  <= vb_clk;
    prev_load <= vb_load;
    prev_data <= vb_data;
    if (mon_clr) begin
      rises <= 0; load_cyc <= 0; load_pulses <= 0; done_cnt <= 0; busy_cyc <= 0;
      last_fall <= 0; load_rise <= 0; data_err <= 0; bits <= '0;
    end else begin
      if (vb_clk && !prev_clk) begin
        rises <= rises + 1;
        bits  <= {bits[62:0], vb_data};
      end
      if (!vb_clk && prev_clk) last_fall <= cyc;
      if (vb_load) load_cyc <= load_cyc + 1;
      if (vb_load && !prev_load) begin
        load_pulses <= load_pulses + 1;
        load_rise   <= cyc;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cyc <= busy_cyc + 1;
      if (vb_clk && (vb_data !== prev_data)) data_err <= data_err + 1;
    end
  end

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic clear_mon;
    mon_clr = 1'b1;
    tick;
    mon_clr = 1'b0;
  endtask

  logic [15:0] words3 [3];
  logic [3:0]  bexp [10];

  initial begin
    bit   ok;
    int   viol;
    int   r;
    logic c4, c5, pc;

    words3 = '{16'h0001, 16'h8000, 16'hFFFF};
    bexp   = '{4'b0100, 4'b1100, 4'b0000, 4'b1000, 4'b0000,
               4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0000};
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0;

    // Reset state
    repeat (3) tick;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_vb_clk", 64'(vb_clk), 64'd0);
    check("rst_vb_data", 64'(vb_data), 64'd0);
    check("rst_vb_load", 64'(vb_load), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_words", 64'(words_shifted), 64'd0);
    reset = 1'b0;
    tick;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    // Single-word frame A5C3, with in_valid noise while shifting
    clear_mon;
    in_data = 16'hA5C3; in_last = 1'b1; in_valid = 1'b1;
    tick;
    check("t1_first_bit", 64'(vb_data), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready_low", 64'(in_ready), 64'd0);
    viol = 0; c4 = 1'bx; c5 = 1'bx;
    for (int i = 2; i <= 100; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      tick;
      if (in_ready !== 1'b0) viol++;
      if (i == 4) c4 = vb_clk;
      if (i == 5) c5 = vb_clk;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("t1_clk_t4", 64'(c4), 64'd0);
    check("t1_clk_t5", 64'(c5), 64'd1);
    check("t1_ready_while_shift", 64'(viol), 64'd0);
    wait_done(200, ok);
    check("t1_done_seen", 64'(ok), 64'd1);
    tick;
    check("t1_ready_after_done", 64'(in_ready), 64'd1);
    check("t1_idle_busy", 64'(busy), 64'd0);
    tick;
    check("t1_rises", 64'(rises), 64'd16);
    check("t1_bits", 64'(bits[15:0]), 64'hA5C3);
    check("t1_load_cycles", 64'(load_cyc), 64'd4);
    check("t1_load_pulses", 64'(load_pulses), 64'd1);
    check("t1_load_after_fall", 64'(load_rise - last_fall), 64'd4);
    check("t1_done_count", 64'(done_cnt), 64'd1);
    check("t1_busy_cycles", 64'(busy_cyc), 64'd137);
    check("t1_words", 64'(words_shifted), 64'd1);
    check("t1_data_stable", 64'(data_err), 64'd0);

    // Three back-to-back words, in_valid held high
    clear_mon;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = words3[k];
      in_last = (k == 2);
      ok = 1'b0;
      for (int j = 0; j < 400 && !ok; j++) begin
        if (in_ready === 1'b1) ok = 1'b1;
        tick;
      end
      check($sformatf("t2_accept%0d", k), 64'(ok), 64'd1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(500, ok);
    check("t2_done_seen", 64'(ok), 64'd1);
    tick; tick;
    check("t2_rises", 64'(rises), 64'd48);
    check("t2_bits", 64'(bits[47:0]), 64'h0001_8000_FFFF);
    check("t2_load_pulses", 64'(load_pulses), 64'd1);
    check("t2_busy_cycles", 64'(busy_cyc), 64'd395);
    check("t2_words", 64'(words_shifted), 64'd3);
    check("t2_done_count", 64'(done_cnt), 64'd1);
    check("t2_data_stable", 64'(data_err), 64'd0);

    // Stall in WAIT_WORD, then finish the frame
    clear_mon;
    in_data = 16'h1234; in_last = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    ok = 1'b0;
    for (int j = 0; j < 300 && !ok; j++) begin
      tick;
      if (in_ready === 1'b1) ok = 1'b1;
    end
    check("t3_reached_wait", 64'(ok), 64'd1);
    viol = 0;
    repeat (50) begin
      tick;
      if (vb_clk !== 1'b0 || vb_load !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) viol++;
    end
    check("t3_stall_outputs", 64'(viol), 64'd0);
    check("t3_stall_words", 64'(words_shifted), 64'd1);
    in_data = 16'h00FF; in_last = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(300, ok);
    check("t3_done_seen", 64'(ok), 64'd1);
    tick; tick;
    check("t3_rises", 64'(rises), 64'd32);
    check("t3_bits", 64'(bits[31:0]), 64'h1234_00FF);
    check("t3_load_pulses", 64'(load_pulses), 64'd1);
    check("t3_words", 64'(words_shifted), 64'd2);
    check("t3_done_count", 64'(done_cnt), 64'd1);

    // Reset at the 7th rising edge of a last word
    clear_mon;
    in_data = 16'hFFFF; in_last = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    r = 0; pc = vb_clk;
    for (int j = 0; j < 200 && r < 7; j++) begin
      tick;
      if (vb_clk === 1'b1 && pc === 1'b0) r++;
      pc = vb_clk;
    end
    check("t4_seven_rises", 64'(r), 64'd7);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("t4_in_ready", 64'(in_ready), 64'd0);
    check("t4_vb_clk", 64'(vb_clk), 64'd0);
    check("t4_vb_data", 64'(vb_data), 64'd0);
    check("t4_vb_load", 64'(vb_load), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    check("t4_words", 64'(words_shifted), 64'd0);
    tick;
    check("t4_ready_after", 64'(in_ready), 64'd1);
    repeat (300) tick;
    check("t4_no_load", 64'(load_pulses), 64'd0);
    check("t4_no_done", 64'(done_cnt), 64'd0);
    check("t4_still_idle", 64'(busy), 64'd0);

    // CLK_DIV=1, DATA_WIDTH=2, LOAD_LEN=3 cycle-exact sequence for 2'b10
    b_in_data = 2'b10; b_in_last = 1'b1; b_in_valid = 1'b1;
    tick;
    b_in_valid = 1'b0; b_in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("b_cyc%0d", i + 1), 64'({b_vb_clk, b_vb_data, b_vb_load, b_done}),
            64'(bexp[i]));
      if (i < 9) tick;
    end
    check("b_ready_after", 64'(b_in_ready), 64'd1);
    check("b_busy_after", 64'(b_busy), 64'd0);
    check("b_words", 64'(b_words_shifted), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
